// File: rtl/cadd_acc_if.sv
// cadd_acc_if -- beat/result bus for the complex add/accumulate block.
//   in_valid/in_ready : input beat handshake (master -> slave)
//   op                : 00 ADD, 01 SUB, 10 ACC, 11 CONJ
//   in_last           : closes an ACC packet
//   ar, ai, br, bi    : signed operands a = ar + j*ai, b = br + j*bi
//   out_valid/out_ready : result handshake (slave -> master)
//   sr, si            : signed result, SIZEIN+GUARD bits each
//   out_ovf           : overflow flag attached to the result
interface cadd_acc_if #(
    parameter int SIZEIN = 16,
    parameter int GUARD  = 4
);
    localparam int OUTW = SIZEIN + GUARD;

    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               op;
    logic                     in_last;
    logic signed [SIZEIN-1:0] ar;
    logic signed [SIZEIN-1:0] ai;
    logic signed [SIZEIN-1:0] br;
    logic signed [SIZEIN-1:0] bi;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUTW-1:0]   sr;
    logic signed [OUTW-1:0]   si;
    logic                     out_ovf;

    modport master (
        output in_valid, op, in_last, ar, ai, br, bi, out_ready,
        input  in_ready, out_valid, sr, si, out_ovf
    );

    modport slave (
        input  in_valid, op, in_last, ar, ai, br, bi, out_ready,
        output in_ready, out_valid, sr, si, out_ovf
    );
endinterface

// File: rtl/cadd_acc.sv
// cadd_acc -- two-stage complex adder / packet accumulator.
//   clk : clock, all state on the rising edge
//   rst : synchronous active-high reset, discards everything in flight
//   bus : cadd_acc_if slave port (input beats, results)
// Stage 1 registers the beat; stage 2 computes ADD/SUB/CONJ directly or
// folds an ACC beat into the accumulator, emitting the sum on in_last.
// Both stages move only when the output register is empty or being drained.
module cadd_acc #(
    parameter int SIZEIN = 16,
    parameter int GUARD  = 4,
    parameter int SAT    = 0
) (
    input  logic      clk,
    input  logic      rst,
    cadd_acc_if.slave bus
);
    localparam int OUTW = SIZEIN + GUARD;
    localparam int NW   = SIZEIN + 1;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ACC  = 2'b10,
        OP_CONJ = 2'b11
    } op_e;

    logic                   adv;
    logic                   s1_valid_q, s1_valid_d;
    op_e                    s1_op_q, s1_op_d;
    logic                   s1_last_q, s1_last_d;
    // index 0 = real component, index 1 = imaginary component
    logic [1:0][SIZEIN-1:0] s1_a_q, s1_a_d;
    logic [1:0][SIZEIN-1:0] s1_b_q, s1_b_d;
    logic [1:0][OUTW-1:0]   acc_q, acc_d;
    logic                   sticky_q, sticky_d;
    logic                   out_valid_q, out_valid_d;
    logic [1:0][OUTW-1:0]   res_q, res_d;
    logic                   out_ovf_q, out_ovf_d;

    logic [1:0][OUTW-1:0]   arith_w;
    logic [1:0][OUTW-1:0]   acc_new_w;
    logic [1:0]             acc_ovf_w;

    assign adv = !out_valid_q || bus.out_ready;

    for (genvar gi = 0; gi < 2; gi++) begin : g_comp
        logic [NW-1:0] a_ext;
        logic [NW-1:0] b_ext;
        logic [NW-1:0] opnd_sum;
        logic [NW-1:0] opnd_dif;
        logic [NW-1:0] opnd_res;
        logic [OUTW:0] acc_sum;
        logic          use_sub;

        assign a_ext    = {s1_a_q[gi][SIZEIN-1], s1_a_q[gi]};
        assign b_ext    = {s1_b_q[gi][SIZEIN-1], s1_b_q[gi]};
        assign opnd_sum = a_ext + b_ext;
        assign opnd_dif = a_ext - b_ext;
        // CONJ subtracts only on the imaginary component
        assign use_sub  = (s1_op_q == OP_SUB) || ((gi == 1) && (s1_op_q == OP_CONJ));
        assign opnd_res = use_sub ? opnd_dif : opnd_sum;
        assign arith_w[gi] = {{GUARD{opnd_res[NW-1]}}, opnd_res};

        // One extra bit so signed overflow shows up as the top two bits differing.
        assign acc_sum = {acc_q[gi][OUTW-1], acc_q[gi]}
                       + {{GUARD{opnd_sum[NW-1]}}, opnd_sum};
        assign acc_ovf_w[gi] = acc_sum[OUTW] ^ acc_sum[OUTW-1];

        if (SAT != 0) begin : g_sat
            // The true sign (bit OUTW) picks the clamp direction.
            assign acc_new_w[gi] = !acc_ovf_w[gi] ? acc_sum[OUTW-1:0] :
                                   (acc_sum[OUTW] ? {1'b1, {(OUTW-1){1'b0}}}
                                                  : {1'b0, {(OUTW-1){1'b1}}});
        end else begin : g_wrap
            assign acc_new_w[gi] = acc_sum[OUTW-1:0];
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_last_d   = s1_last_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        out_ovf_d   = out_ovf_q;

        if (adv) begin
            s1_valid_d  = bus.in_valid;
            s1_op_d     = op_e'(bus.op);
            s1_last_d   = bus.in_last;
            s1_a_d      = {bus.ai, bus.ar};
            s1_b_d      = {bus.bi, bus.br};
            out_valid_d = 1'b0;

            if (s1_valid_q) begin
                if (s1_op_q == OP_ACC) begin
                    if (s1_last_q) begin
                        // Emit the updated sum and restart the packet from zero.
                        out_valid_d = 1'b1;
                        res_d       = acc_new_w;
                        out_ovf_d   = sticky_q | (|acc_ovf_w);
                        acc_d       = '0;
                        sticky_d    = 1'b0;
                    end else begin
                        acc_d       = acc_new_w;
                        sticky_d    = sticky_q | (|acc_ovf_w);
                    end
                end else begin
                    out_valid_d = 1'b1;
                    res_d       = arith_w;
                    out_ovf_d   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_ADD;
            s1_last_q   <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_last_q   <= s1_last_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.sr        = res_q[0];
    assign bus.si        = res_q[1];
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: doc/cadd_acc.md
CADD_ACC -- requirements
Module: cadd_acc

Interface
REQ-001 SHALL have parameter SIZEIN, default 16: signed operand width per component.
REQ-002 SHALL have parameter GUARD, default 4, legal range 1..16: growth bits; OUTW = SIZEIN+GUARD.
REQ-003 SHALL have parameter SAT, default 0: 1 = saturate accumulator, 0 = two's-complement wrap.
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  input beat valid.
REQ-007 in_ready  out  1  block can accept a beat.
REQ-008 op  in  2  00 ADD, 01 SUB, 10 ACC, 11 CONJ.
REQ-009 in_last  in  1  last beat of an ACC packet; ignored for other ops.
REQ-010 ar, ai, br, bi  in  SIZEIN each  signed operands a = ar + j*ai, b = br + j*bi.
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  downstream accepts the result.
REQ-013 sr, si  out  OUTW each  signed result.
REQ-014 out_ovf  out  1  overflow flag for the result.

Function
REQ-015 A beat SHALL transfer when in_valid and in_ready are both 1; a result SHALL transfer when out_valid and out_ready are both 1.
REQ-016 The pipeline SHALL have two stages: S1 registers op, in_last and operands; S2 computes and registers the result.
REQ-017 Advance: adv = !out_valid || out_ready; in_ready SHALL equal adv; S1 and S2 SHALL load only when adv = 1.
REQ-018 Latency SHALL be 2 cycles from accept to out_valid when there is no stall, with throughput of one beat per cycle.
REQ-019 ADD result SHALL be (ar+br, ai+bi); SUB result SHALL be (ar-br, ai-bi); CONJ result SHALL be (ar+br, ai-bi).
REQ-020 ADD/SUB/CONJ results SHALL be computed at SIZEIN+1 bits and sign-extended to OUTW; out_ovf SHALL be 0; they SHALL NOT touch the accumulator.
REQ-021 ACC: on each S1-to-S2 advance, acc_r += ar+br and acc_i += ai+bi at OUTW bits.
REQ-022 An ACC beat without in_last SHALL produce no output.
REQ-023 An ACC beat with in_last SHALL output the updated acc with out_valid = 1 and SHALL clear acc to 0 in the same cycle, so the next ACC beat starts from 0.
REQ-024 Accumulator overflow of either component SHALL clamp to +(2^(OUTW-1))-1 or -2^(OUTW-1) when SAT = 1, and SHALL wrap modulo 2^OUTW when SAT = 0.
REQ-025 An overflow SHALL set a sticky packet flag; out_ovf on the in_last result SHALL equal that flag including the current beat; the flag SHALL clear with acc.
REQ-026 Once saturated, the accumulator SHALL continue to accumulate from the clamped value.
REQ-027 Interleaving non-ACC ops inside an ACC packet SHALL be allowed; acc and the flag SHALL be preserved across them.
REQ-028 sr, si and out_ovf SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-029 S1 holding a bubble (no valid beat) SHALL not alter acc.

Reset
REQ-030 On rst = 1: out_valid = 0, sr = si = 0, out_ovf = 0, S1/S2 valids = 0, acc = 0, sticky flag = 0; in_ready SHALL read 1 in the cycle after rst deasserts.
REQ-031 rst SHALL override any simultaneous transfer; beats and partial ACC packets in flight SHALL be discarded.

Verification
REQ-032 ADD with ar = br = 32767, ai = bi = -32768, out_ready = 1 -> 2 cycles later sr = 65534, si = -65536, out_ovf = 0.
REQ-033 SUB with ar = 5, br = -3, ai = 1, bi = 4 -> (8, -3); then CONJ with ar = 2, br = 3, ai = 7, bi = 2 -> (5, 5) on the next cycle.
REQ-034 ACC, 4 beats of a = (600, -600), b = (400, -400), in_last on beat 4 -> exactly one output (4000, -4000); a following 1-beat packet (1, 1) + (0, 0) -> (1, 1).
REQ-035 ACC with SIZEIN = 16, GUARD = 4: 16 beats of 32767 + 32767 in real and 0 in imaginary, last on beat 16 -> SAT = 1: sr = 524287, out_ovf = 1; SAT = 0: sr = -32, out_ovf = 1.
REQ-036 Continuous ADD stream with out_ready = 0 for 3 cycles -> in_ready = 0 during the stall, outputs held stable, and no beat lost or duplicated across 10 beats.
REQ-037 2 ACC beats (100, 100), then rst for 1 cycle, then 1 ACC beat (5, 5) with last -> result (5, 5), out_ovf = 0.
